// File: rtl/cpu_pkg.sv
// Shared pipeline control types and constants for the vector CPU.
// ctrl_t carries the per-stage control bundle. The stage-specific structs are
// the bundles held by the ID/EX and MEM/WB stage registers.
package cpu_pkg;

  typedef struct packed {
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       valid;
  } ctrl_t;

  // ID/EX bundle: source addresses plus the control bundle
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    ctrl_t      ctrl;
  } idex_t;

  // MEM/WB bundle: memwrite is no longer needed past M
  typedef struct packed {
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       valid;
  } memwb_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [3:0]  REG_ZERO  = 4'b0;

endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// Bus between the hazard unit/decode logic and the pipeline control registers.
// master: drives PC/instruction/decoded fields and stall/flush controls, and
//         observes the stage fields.
// slave : the pipe_ctrl_regs block.
interface pipe_ctrl_regs_if #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned STALL_CW = 16
) ();

  logic [31:0]         PCNextF;
  logic [INSTR_W-1:0]  InstrF;
  logic                StallF;
  logic                StallD;
  logic                FlushD;
  logic                FlushE;
  logic [3:0]          RA1D;
  logic [3:0]          RA2D;
  logic [3:0]          WA3D;
  logic                RegWriteD;
  logic                MemtoRegD;
  logic                MemWriteD;
  logic                StallCntClr;

  logic [31:0]         PCF;
  logic [INSTR_W-1:0]  InstrD;
  logic                ValidD;
  logic                ValidE;
  logic                ValidM;
  logic                ValidW;
  logic [3:0]          RA1E;
  logic [3:0]          RA2E;
  logic [3:0]          WA3E;
  logic                RegWriteE;
  logic                MemtoRegE;
  logic                MemWriteE;
  logic [3:0]          WA3M;
  logic                RegWriteM;
  logic                MemtoRegM;
  logic                MemWriteM;
  logic [3:0]          WA3W;
  logic                RegWriteW;
  logic                MemtoRegW;
  logic [STALL_CW-1:0] StallCnt;

  modport master (
    output PCNextF, InstrF, StallF, StallD, FlushD, FlushE, RA1D, RA2D, WA3D,
           RegWriteD, MemtoRegD, MemWriteD, StallCntClr,
    input  PCF, InstrD, ValidD, ValidE, ValidM, ValidW, RA1E, RA2E, WA3E,
           RegWriteE, MemtoRegE, MemWriteE, WA3M, RegWriteM, MemtoRegM, MemWriteM,
           WA3W, RegWriteW, MemtoRegW, StallCnt
  );

  modport slave (
    input  PCNextF, InstrF, StallF, StallD, FlushD, FlushE, RA1D, RA2D, WA3D,
           RegWriteD, MemtoRegD, MemWriteD, StallCntClr,
    output PCF, InstrD, ValidD, ValidE, ValidM, ValidW, RA1E, RA2E, WA3E,
           RegWriteE, MemtoRegE, MemWriteE, WA3M, RegWriteM, MemtoRegM, MemWriteM,
           WA3W, RegWriteW, MemtoRegW, StallCnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with clear and enable.
// Ports: clk_i, rst_n (async, active-low), en_i (load), clr_i (load zero,
// wins over en_i), d_i / q_o (Width bits).
module pipe_stage_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Pipeline control/address registers: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Tracks only control and register addresses; datapath values live elsewhere.
// Ports: clk, rst_n (async, active-low), bus (pipe_ctrl_regs_if.slave) carrying
// the fetch/decode inputs, hazard controls and per-stage control outputs.
module pipe_ctrl_regs
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned STALL_CW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_regs_if.slave  bus
);

  logic [31:0]         pcf_d, pcf_q;
  logic [INSTR_W-1:0]  instrd_d, instrd_q;
  logic                validd_d, validd_q;
  logic [STALL_CW-1:0] stall_cnt_d, stall_cnt_q;

  idex_t  idex_d, idex_q;
  ctrl_t  exmem_q;
  memwb_t memwb_d, memwb_q;

  // PC, IF/ID and stall counter next state
  always_comb begin
    pcf_d = pcf_q;
    if (!bus.StallF) begin
      pcf_d = bus.PCNextF;
    end

    instrd_d = instrd_q;
    validd_d = validd_q;
    if (bus.FlushD) begin
      instrd_d = INSTR_W'(NOP_INSTR);
      validd_d = 1'b0;
    end else if (!bus.StallD) begin
      instrd_d = bus.InstrF;
      validd_d = 1'b1;
    end

    // A flushed IF/ID is not a held one, so it does not count as a stall cycle
    stall_cnt_d = stall_cnt_q;
    if (bus.StallCntClr) begin
      stall_cnt_d = '0;
    end else if (bus.StallD && !bus.FlushD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q       <= RESET_PC;
      instrd_q    <= INSTR_W'(NOP_INSTR);
      validd_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instrd_q    <= instrd_d;
      validd_q    <= validd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ID/EX: a clear loads all-zero, i.e. a bubble with REG_ZERO addresses
  always_comb begin
    idex_d.ra1           = bus.RA1D;
    idex_d.ra2           = bus.RA2D;
    idex_d.ctrl.wa3      = bus.WA3D;
    idex_d.ctrl.regwrite = bus.RegWriteD;
    idex_d.ctrl.memtoreg = bus.MemtoRegD;
    idex_d.ctrl.memwrite = bus.MemWriteD;
    idex_d.ctrl.valid    = 1'b1;
  end

  pipe_stage_reg #(
    .Width ($bits(idex_t))
  ) u_idex (
    .clk_i (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .clr_i (bus.FlushE | ~validd_q),
    .d_i   (idex_d),
    .q_o   (idex_q)
  );

  pipe_stage_reg #(
    .Width ($bits(ctrl_t))
  ) u_exmem (
    .clk_i (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (idex_q.ctrl),
    .q_o   (exmem_q)
  );

  always_comb begin
    memwb_d.wa3      = exmem_q.wa3;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.valid    = exmem_q.valid;
  end

  pipe_stage_reg #(
    .Width ($bits(memwb_t))
  ) u_memwb (
    .clk_i (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (memwb_d),
    .q_o   (memwb_q)
  );

  assign bus.PCF       = pcf_q;
  assign bus.InstrD    = instrd_q;
  assign bus.ValidD    = validd_q;
  assign bus.StallCnt  = stall_cnt_q;

  assign bus.RA1E      = idex_q.ra1;
  assign bus.RA2E      = idex_q.ra2;
  assign bus.WA3E      = idex_q.ctrl.wa3;
  assign bus.RegWriteE = idex_q.ctrl.regwrite;
  assign bus.MemtoRegE = idex_q.ctrl.memtoreg;
  assign bus.MemWriteE = idex_q.ctrl.memwrite;
  assign bus.ValidE    = idex_q.ctrl.valid;

  assign bus.WA3M      = exmem_q.wa3;
  assign bus.RegWriteM = exmem_q.regwrite;
  assign bus.MemtoRegM = exmem_q.memtoreg;
  assign bus.MemWriteM = exmem_q.memwrite;
  assign bus.ValidM    = exmem_q.valid;

  assign bus.WA3W      = memwb_q.wa3;
  assign bus.RegWriteW = memwb_q.regwrite;
  assign bus.MemtoRegW = memwb_q.memtoreg;
  assign bus.ValidW    = memwb_q.valid;

endmodule
